// File: rtl/m_unit_dispatch.sv
// PCPI front end that decodes RV32M requests, issues them to riscv_m_unit and returns the result.
// Optional last-result reuse is built only when M_RESULT_REUSE_EN is defined.
module m_unit_dispatch #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        m_valid,
  output logic [31:0] m_instruction,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_wr,
  input  logic [31:0] m_rd,
  input  logic        m_busy,
  input  logic        m_ready,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] insn_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [31:0] result_q;
  logic        wr_q;
  logic        abort_q;
  logic        timeout_q;
  logic [9:0]  watchdog;
  logic        hit;
  logic        reuse_hit;
  logic [31:0] reuse_result;
  logic        wd_expire;
  logic        abort_now;

  assign hit       = pcpi_valid && (pcpi_insn[6:0] == 7'h33) && (pcpi_insn[31:25] == 7'h01);
  assign wd_expire = (state == S_WAIT) && !m_ready && (watchdog == WD_LAST);
  // A core that drops pcpi_valid mid-op no longer wants the answer, even if it arrives this cycle.
  assign abort_now = abort_q || !pcpi_valid;

`ifdef M_RESULT_REUSE_EN
  logic        reuse_valid;
  logic [2:0]  reuse_funct3;
  logic [31:0] reuse_rs1;
  logic [31:0] reuse_rs2;
  logic [31:0] reuse_value;

  assign reuse_hit    = hit && reuse_valid && (pcpi_insn[14:12] == reuse_funct3) &&
                        (pcpi_rs1 == reuse_rs1) && (pcpi_rs2 == reuse_rs2);
  assign reuse_result = reuse_value;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reuse_valid  <= 1'b0;
      reuse_funct3 <= '0;
      reuse_rs1    <= '0;
      reuse_rs2    <= '0;
      reuse_value  <= '0;
    end else if ((state == S_WAIT) && m_ready) begin
      reuse_valid  <= 1'b1;
      reuse_funct3 <= insn_q[14:12];
      reuse_rs1    <= rs1_q;
      reuse_rs2    <= rs2_q;
      reuse_value  <= m_rd;
    end else if (wd_expire) begin
      reuse_valid  <= 1'b0;
    end
  end
`else
  assign reuse_hit    = 1'b0;
  assign reuse_result = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (hit) begin
          state_next = reuse_hit ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!pcpi_valid) begin
          state_next = S_IDLE;
        end else if (!m_busy) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (m_ready || wd_expire) begin
          state_next = abort_now ? S_DRAIN : S_RESP;
        end
      end
      S_RESP:  state_next = S_DRAIN;
      S_DRAIN: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    m_valid    = 1'b0;
    case (state)
      S_ISSUE: begin
        pcpi_wait = 1'b1;
        m_valid   = pcpi_valid && !m_busy;
      end
      S_WAIT: pcpi_wait = 1'b1;
      S_RESP: begin
        pcpi_ready = 1'b1;
        pcpi_wr    = wr_q;
      end
      default: ;
    endcase
  end

  // Operand latch, result capture and the WAIT watchdog.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      insn_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      result_q  <= '0;
      wr_q      <= 1'b0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
      watchdog  <= '0;
    end else begin
      timeout_q <= wd_expire;
      case (state)
        S_IDLE: begin
          if (hit) begin
            insn_q  <= pcpi_insn;
            rs1_q   <= pcpi_rs1;
            rs2_q   <= pcpi_rs2;
            abort_q <= 1'b0;
            if (reuse_hit) begin
              result_q <= reuse_result;
              wr_q     <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (pcpi_valid && !m_busy) begin
            watchdog <= '0;
          end
        end
        S_WAIT: begin
          watchdog <= watchdog + 10'd1;
          if (!pcpi_valid) begin
            abort_q <= 1'b1;
          end
          if (m_ready) begin
            if (!abort_now) begin
              result_q <= m_rd;
              wr_q     <= m_wr;
            end
          end else if (wd_expire && !abort_now) begin
            result_q <= '0;
            wr_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pcpi_rd       = result_q;
  assign m_instruction = insn_q;
  assign m_rs1         = rs1_q;
  assign m_rs2         = rs2_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_m_unit_dispatch.sv
// Randomized bench for m_unit_dispatch; a behavioural M-unit stub answers issued ops and a
// transaction-level model predicts PCPI timing, results, watchdog and reuse behaviour.
module tb_m_unit_dispatch;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [31:0] pcpi_rs1 = '0;
  logic [31:0] pcpi_rs2 = '0;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        m_valid;
  logic [31:0] m_instruction;
  logic [31:0] m_rs1;
  logic [31:0] m_rs2;
  logic        m_wr = 1'b0;
  logic [31:0] m_rd = '0;
  logic        m_busy = 1'b0;
  logic        m_ready = 1'b0;
  logic        timeout_err;

  int total = 0;
  int bad = 0;
  int tx_id = 0;

  // stub controls and state
  int          stub_lat = 1;
  bit          stub_hang = 1'b0;
  int          busy_cycles = 0;
  bit          stray_en = 1'b0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] res = '0;

  // model state
  logic [31:0] prev_rd = '0;
  logic [31:0] last_rd = '0;
  bit          rv_valid = 1'b0;
  logic [2:0]  rv_f3 = '0;
  logic [31:0] rv_rs1 = '0;
  logic [31:0] rv_rs2 = '0;
  logic [31:0] rv_res = '0;

  m_unit_dispatch #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pcpi_valid   (pcpi_valid),
    .pcpi_insn    (pcpi_insn),
    .pcpi_rs1     (pcpi_rs1),
    .pcpi_rs2     (pcpi_rs2),
    .pcpi_wr      (pcpi_wr),
    .pcpi_rd      (pcpi_rd),
    .pcpi_wait    (pcpi_wait),
    .pcpi_ready   (pcpi_ready),
    .m_valid      (m_valid),
    .m_instruction(m_instruction),
    .m_rs1        (m_rs1),
    .m_rs2        (m_rs2),
    .m_wr         (m_wr),
    .m_rd         (m_rd),
    .m_busy       (m_busy),
    .m_ready      (m_ready),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: r = (b == 0) ? a : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [6:0] opc);
    return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), opc};
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Behavioural riscv_m_unit: busy while computing, one-cycle ready after stub_lat cycles.
  always begin
    @(negedge clk);
    if (!resetn) begin
      pend = 1'b0;
    end else if (m_valid) begin
      pend = 1'b1;
      cnt  = stub_hang ? 0 : stub_lat;
      res  = ref_m(m_instruction[14:12], m_rs1, m_rs2);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    m_wr    = 1'b0;
    m_rd    = $urandom;
    if (pend) begin
      m_busy = 1'b1;
      if (cnt == 1) begin
        m_ready = 1'b1;
        m_wr    = 1'b1;
        m_rd    = res;
        m_busy  = 1'b0;
        pend    = 1'b0;
      end else if (cnt > 1) begin
        cnt--;
      end
    end else begin
      m_busy = (busy_cycles > 0);
      if (busy_cycles > 0) busy_cycles--;
      if (stray_en && $urandom_range(0, 3) == 0) begin
        m_ready = 1'b1;
        m_wr    = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL tx%0d %s: got %h expected %h", tx_id, tag, got, exp);
    end
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    pcpi_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    prev_rd = '0;
    rv_valid = 1'b0;
  endtask

  // One core request; offsets are relative to the issue cycle, 0 means unused.
  task automatic applyStimulus(input logic [31:0] insn, input logic [31:0] rs1,
                               input logic [31:0] rs2, input int b, input int lat,
                               input bit hang, input int drop_off, input int rst_off);
    bit          is_m;
    bit          reuse;
    bit          exp_issue;
    bit          exp_ready;
    bit          exp_to;
    bit          ready_prev;
    bit          exp_w;
    int          issue_c;
    int          resp_c;
    int          drop_c;
    int          rst_c;
    int          wait_end;
    int          win;
    int          n_valid;
    int          first_valid;
    int          n_ready;
    int          ready_c;
    int          n_to;
    int          to_c;
    int          bad_wait;
    int          bad_wr;
    logic [31:0] want;
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    logic [31:0] mi;
    logic [31:0] ms1;
    logic [31:0] ms2;
    logic        exp_wr;
    logic        got_wr;

    tx_id++;
    is_m  = (insn[6:0] == 7'h33) && (insn[31:25] == 7'h01);
    want  = ref_m(insn[14:12], rs1, rs2);
    reuse = 1'b0;
`ifdef M_RESULT_REUSE_EN
    reuse = is_m && rv_valid && rv_f3 == insn[14:12] && rv_rs1 == rs1 && rv_rs2 == rs2;
`endif
    issue_c   = (b > 1) ? b : 1;
    exp_issue = is_m && !reuse;
    if (!exp_issue) begin
      drop_off = 0;
      rst_off  = 0;
    end
    resp_c    = reuse ? 1 : (hang ? issue_c + TIMEOUT + 1 : issue_c + lat + 1);
    drop_c    = (drop_off > 0) ? issue_c + drop_off : -1;
    rst_c     = (rst_off > 0) ? issue_c + rst_off : -1;
    exp_ready = is_m && drop_c < 0 && rst_c < 0;
    exp_to    = exp_issue && hang && rst_c < 0;
    exp_rd    = reuse ? rv_res : (hang ? 32'h0 : want);
    exp_wr    = reuse ? 1'b1 : !hang;
    wait_end  = (rst_c >= 0) ? rst_c - 1 : resp_c - 1;
    win       = is_m ? resp_c + 3 : 20;

    n_valid = 0; first_valid = -1; n_ready = 0; ready_c = -1; n_to = 0; to_c = -1;
    bad_wait = 0; bad_wr = 0; got_rd = '0; got_wr = 1'b0; mi = '0; ms1 = '0; ms2 = '0;
    ready_prev = 1'b0;

    @(negedge clk);
    busy_cycles = b;
    stub_lat    = lat;
    stub_hang   = hang;
    @(posedge clk);
    #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = rs1;
    pcpi_rs2   = rs2;
    for (int c = 0; c <= win; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        if (c == drop_c || ready_prev) pcpi_valid = 1'b0;
        if (c == rst_c) resetn = 1'b0;
        if (rst_c >= 0 && c == rst_c + 2) resetn = 1'b1;
      end
      @(negedge clk);
      ready_prev = pcpi_ready;
      if (m_valid) begin
        n_valid++;
        if (first_valid < 0) begin
          first_valid = c;
          mi = m_instruction; ms1 = m_rs1; ms2 = m_rs2;
        end
      end
      if (pcpi_ready) begin
        n_ready++; ready_c = c; got_rd = pcpi_rd; got_wr = pcpi_wr;
      end
      if (timeout_err) begin
        n_to++; to_c = c;
      end
      exp_w = exp_issue && c >= 1 && c <= wait_end;
      if (pcpi_wait !== exp_w) bad_wait++;
      if (pcpi_wr && !pcpi_ready) bad_wr++;
    end
    @(posedge clk);
    #1;
    pcpi_valid = 1'b0;

    if (rst_c >= 0) begin
      prev_rd  = '0;
      rv_valid = 1'b0;
    end else begin
      if (exp_ready) prev_rd = exp_rd;
      if (exp_issue) begin
        if (hang) begin
          rv_valid = 1'b0;
        end else begin
          rv_valid = 1'b1; rv_f3 = insn[14:12]; rv_rs1 = rs1; rv_rs2 = rs2; rv_res = want;
        end
      end
    end
    if (n_ready > 0) last_rd = got_rd;

    checkOutput("m_valid_count", 32'(n_valid), 32'(exp_issue));
    if (exp_issue) begin
      checkOutput("issue_cycle", 32'(first_valid), 32'(issue_c));
      checkOutput("m_instruction", mi, insn);
      checkOutput("m_rs1", ms1, rs1);
      checkOutput("m_rs2", ms2, rs2);
    end
    checkOutput("ready_count", 32'(n_ready), 32'(exp_ready));
    if (exp_ready) begin
      checkOutput("ready_cycle", 32'(ready_c), 32'(resp_c));
      checkOutput("pcpi_rd", got_rd, exp_rd);
      checkOutput("pcpi_wr", 32'(got_wr), 32'(exp_wr));
    end
    checkOutput("wait_shape_errs", 32'(bad_wait), 32'd0);
    checkOutput("wr_unqualified", 32'(bad_wr), 32'd0);
    checkOutput("timeout_count", 32'(n_to), 32'(exp_to));
    if (exp_to) checkOutput("timeout_cycle", 32'(to_c), 32'(resp_c));
    checkOutput("rd_hold", pcpi_rd, prev_rd);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] insn;
    logic [2:0]  last_f3;
    logic [31:0] last_a;
    logic [31:0] last_b;
    bit          have_last;
    int          lat;
    int          bsy;
    int          drop_off;

    have_last = 1'b0;
    last_f3 = '0; last_a = '0; last_b = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_pcpi_wait", 32'(pcpi_wait), 32'd0);
    checkOutput("rst_pcpi_ready", 32'(pcpi_ready), 32'd0);
    checkOutput("rst_pcpi_wr", 32'(pcpi_wr), 32'd0);
    checkOutput("rst_pcpi_rd", pcpi_rd, 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_instruction", m_instruction, 32'd0);
    checkOutput("rst_m_rs1", m_rs1, 32'd0);
    checkOutput("rst_m_rs2", m_rs2, 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    applyStimulus(mk_insn(7'h01, 3'd0, 7'h33), 32'h1111FFFF, 32'h1111FFFF, 0, 3, 1'b0, 0, 0);
    checkOutput("spec_mul", last_rd, 32'hDDDC0001);
    applyStimulus(mk_insn(7'h01, 3'd4, 7'h33), 32'hFFFFFFF3, 32'h00000005, 2, 8, 1'b0, 0, 0);
    checkOutput("spec_div", last_rd, 32'hFFFFFFFE);
    applyStimulus(mk_insn(7'h01, 3'd6, 7'h33), 32'hFFFFFFF3, 32'h00000005, 0, 8, 1'b0, 0, 0);
    checkOutput("spec_rem", last_rd, 32'hFFFFFFFD);
    applyStimulus(mk_insn(7'h00, 3'd0, 7'h33), 32'h5, 32'h7, 0, 2, 1'b0, 0, 0);
    applyStimulus(mk_insn(7'h01, 3'd3, 7'h33), 32'h1111FFFF, 32'h1111FFFF, 0, 4, 1'b0, 0, 0);
    checkOutput("spec_mulhu_1", last_rd, 32'h01236543);
    applyStimulus(mk_insn(7'h01, 3'd3, 7'h33), 32'h1111FFFF, 32'h1111FFFF, 0, 4, 1'b0, 0, 0);
    checkOutput("spec_mulhu_2", last_rd, 32'h01236543);
    applyStimulus(mk_insn(7'h01, 3'd3, 7'h33), 32'h1111FFFF, 32'h1111FFFE, 0, 4, 1'b0, 0, 0);
    applyStimulus(mk_insn(7'h01, 3'd0, 7'h33), $urandom, $urandom, 0, TIMEOUT, 1'b0, 0, 0);
    applyStimulus(mk_insn(7'h01, 3'd1, 7'h33), $urandom, $urandom, 1, 5, 1'b0, 2, 0);
    applyStimulus(mk_insn(7'h01, 3'd5, 7'h33), 32'h0000000D, 32'h00000005, 0, 6, 1'b0, 2, 4);
    applyStimulus(mk_insn(7'h01, 3'd3, 7'h33), 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 3, 1'b0, 0, 0);
    checkOutput("spec_mulhu_ff", last_rd, 32'hFFFFFFFE);
    applyStimulus(mk_insn(7'h01, 3'd4, 7'h33), 32'h64, 32'h3, 0, 1, 1'b1, 0, 0);
    checkOutput("timeout_rd", last_rd, 32'h0);
    applyReset();

    stray_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        insn = ($urandom_range(0, 1) == 0) ? mk_insn(7'h20, 3'($urandom), 7'h33)
                                           : mk_insn(7'h01, 3'($urandom), 7'h13);
        a = $urandom;
        b = $urandom;
      end else begin
        if (have_last && $urandom_range(0, 3) == 0) begin
          f3 = last_f3; a = last_a; b = last_b;
        end else begin
          f3 = 3'($urandom); a = pick_op(); b = pick_op();
        end
        insn = mk_insn(7'h01, f3, 7'h33);
        last_f3 = f3; last_a = a; last_b = b; have_last = 1'b1;
      end
      lat      = ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(1, 8));
      bsy      = $urandom_range(0, 3);
      drop_off = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, lat)) : 0;
      applyStimulus(insn, a, b, bsy, lat, 1'b0, drop_off, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
